mode_switch_sequencer: RTL
==========================

Name: mode_switch_sequencer

Overview:
Sequences operating-mode changes for the traffic light system: off, auto, night and manual. It debounces the three raw mode buttons and resolves simultaneous presses by fixed priority. No mode change reaches the lights directly. Each change passes through a yellow phase and then an all-red clearance phase, and the new mode's FSM is restarted before it takes over. Its outputs drive the top-level mode mux and the light overrides.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required before a button level is accepted (>=1)
YELLOW_CYCLES, 3, cycles both approaches are forced yellow when leaving a running mode (>=1)
ALLRED_CYCLES, 2, cycles both approaches are forced red before the new mode is committed (>=1)
CNT_W, 8, phase/debounce counter width; every cycle parameter must be < 2**CNT_W

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
btn1  in  1  raw button, request auto mode (async, bouncy)
btn2  in  1  raw button, request night mode
btn3  in  1  raw button, request manual mode
mode_sel  out  2  committed mode: 00 off, 01 auto, 10 night, 11 manual
force_yellow  out  1  override: both approaches yellow (Va=Vb=1, others 0)
force_red  out  1  override: both approaches red
sub_reset  out  1  active-high restart pulse to mode sub-FSMs
busy  out  1  transition in progress (state != RUN)

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, port reset_n.
- Reset values: mode_sel=00, force_yellow=0, force_red=0, sub_reset=0, busy=0. State=RUN, pending target=00, debouncers cleared to level 0.
- Each button passes through a 2-flop synchronizer and then a debouncer.
  - The debounced level changes only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any mismatch-free cycle clears the count.
- press_k is a 1-cycle pulse on the debounced rising edge.
  - A raw level held from edge N gives press_k high in cycle N+2+DEBOUNCE_CYCLES.
  - Releases produce no event.
- Request resolve: if several press pulses arrive in the same cycle, priority is btn1 > btn2 > btn3. The resolved request is the target code 01/10/11.
- Ignored requests:
  - A target equal to mode_sel while in RUN is ignored.
  - A target equal to pending while busy is ignored.
- States (registered outputs, Moore):
  - RUN: outputs idle, busy=0. On an accepted request, latch pending=target.
    - If mode_sel != 00, go to YELLOW with counter=YELLOW_CYCLES-1.
    - If mode_sel == 00, go straight to ALLRED with counter=ALLRED_CYCLES-1.
  - YELLOW: force_yellow=1, busy=1. When counter==0, go to ALLRED with counter=ALLRED_CYCLES-1; otherwise decrement.
  - ALLRED: force_red=1, sub_reset=1, busy=1. When counter==0, go to RUN and set mode_sel<=pending in the same edge; otherwise decrement.
- Phase lengths: YELLOW lasts exactly YELLOW_CYCLES cycles and ALLRED exactly ALLRED_CYCLES cycles. mode_sel keeps the old value throughout a transition and updates on the first RUN cycle.
- A new accepted request while in YELLOW or ALLRED overwrites pending. The current phase sequence continues without restarting, and the latest request wins at commit.
- A request arriving on the same cycle as the ALLRED exit edge is evaluated against the new mode_sel on the next RUN cycle. Its press pulse is held in a 1-bit/2-bit pending register so it is not lost.
- reset_n asserted mid-transition returns to reset values immediately and asynchronously. No clearance is performed.
- force_yellow and force_red are never high together. The top level gives force_red precedence over force_yellow, and force_yellow precedence over mode_sel.

Decomposition:
- Shared package traffic_pkg holds:
  - mode codes MODE_OFF=2'b00, MODE_AUTO=2'b01, MODE_NIGHT=2'b10, MODE_MANUAL=2'b11
  - seq state enum {S_RUN, S_YELLOW, S_ALLRED}
- One sub-module, btn_debouncer (params DEBOUNCE_CYCLES, CNT_W; ports clk, reset_n, raw, level, press). It contains the synchronizer, counter and edge pulse, and is instantiated three times.

Test Plan:
- Reset, then a single btn1 pulse held 10 cycles from edge 0 (defaults) -> press at cycle 6. ALLRED from cycle 7 for 2 cycles with force_red=sub_reset=1. mode_sel=01 at cycle 9; no YELLOW phase because the start mode was off.
- In auto, press btn2 -> force_yellow high exactly 3 cycles, then force_red plus sub_reset exactly 2 cycles, then mode_sel=10; busy high for all 5 cycles.
- btn1 bouncing (1,0,1,0,1 on alternate cycles) then stable low -> no press, mode_sel and busy unchanged.
- btn2 and btn3 rising on the same edge from off -> target 10 wins; mode_sel=10 after clearance.
- In auto, press btn2, then btn3 during YELLOW -> no extra cycles; after the 3+2 sequence mode_sel=11.
- Press btn3 while in manual -> ignored, busy stays 0. Separately, assert reset_n low during ALLRED -> all outputs 0 at once, mode_sel=00.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared mode codes, sequencer state encoding and request priority for the traffic light mode logic.
package traffic_pkg;

  localparam logic [1:0] MODE_OFF    = 2'b00;
  localparam logic [1:0] MODE_AUTO   = 2'b01;
  localparam logic [1:0] MODE_NIGHT  = 2'b10;
  localparam logic [1:0] MODE_MANUAL = 2'b11;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_YELLOW = 2'd1,
    S_ALLRED = 2'd2
  } seq_state_e;

  // Fixed priority btn1 > btn2 > btn3; MODE_OFF means no request this cycle.
  function automatic logic [1:0] resolve_req(input logic p1, input logic p2, input logic p3);
    logic [1:0] r;
    if (p1) begin
      r = MODE_AUTO;
    end else if (p2) begin
      r = MODE_NIGHT;
    end else if (p3) begin
      r = MODE_MANUAL;
    end else begin
      r = MODE_OFF;
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_debouncer.sv
// Two-flop synchronizer, consecutive-mismatch debouncer and registered rising-edge press pulse.
module btn_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             prev_q;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The accepted level flips on the DEBOUNCE_CYCLES-th disagreeing sample in a row.
  always_comb begin
    level_d = level_q;
    cnt_d   = CNT_ZERO;
    if (sync2_q != level_q) begin
      if (cnt_q == DB_LAST) begin
        level_d = ~level_q;
        cnt_d   = CNT_ZERO;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = CNT_ZERO;
    end
    press_d = level_q & ~prev_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= CNT_ZERO;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/mode_switch_sequencer.sv
// Debounces the mode buttons and walks every mode change through yellow and all-red
// clearance before committing the new mode.
module mode_switch_sequencer
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int YELLOW_CYCLES   = 3,
  parameter int ALLRED_CYCLES   = 2,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn1,
  input  logic       btn2,
  input  logic       btn3,
  output logic [1:0] mode_sel,
  output logic       force_yellow,
  output logic       force_red,
  output logic       sub_reset,
  output logic       busy
);

  localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] A_LAST   = CNT_W'(ALLRED_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             press1_s, press2_s, press3_s;
  logic [1:0]       req_s, eff_s;
  logic             newreq_s;
  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       pending_q, pending_d;
  logic [1:0]       mode_q, mode_d;
  logic [1:0]       hold_q, hold_d;
  logic             fy_q, fy_d, fr_q, fr_d, busy_q, busy_d;

  btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db1 (
    .clk(clk), .reset_n(reset_n), .raw(btn1), .level(), .press(press1_s));
  btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db2 (
    .clk(clk), .reset_n(reset_n), .raw(btn2), .level(), .press(press2_s));
  btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db3 (
    .clk(clk), .reset_n(reset_n), .raw(btn3), .level(), .press(press3_s));

  assign req_s    = resolve_req(press1_s, press2_s, press3_s);
  // A request caught on the commit edge is replayed from hold_q on the first RUN cycle.
  assign eff_s    = (req_s != MODE_OFF) ? req_s : hold_q;
  assign newreq_s = (req_s != MODE_OFF) && (req_s != pending_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    mode_d    = mode_q;
    hold_d    = hold_q;
    case (state_q)
      S_RUN: begin
        hold_d = MODE_OFF;
        if ((eff_s != MODE_OFF) && (eff_s != mode_q)) begin
          pending_d = eff_s;
          if (mode_q != MODE_OFF) begin
            state_d = S_YELLOW;
            cnt_d   = Y_LAST;
          end else begin
            state_d = S_ALLRED;
            cnt_d   = A_LAST;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_YELLOW: begin
        if (newreq_s) pending_d = req_s;
        else          pending_d = pending_q;
        if (cnt_q == CNT_ZERO) begin
          state_d = S_ALLRED;
          cnt_d   = A_LAST;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_ALLRED: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = S_RUN;
          mode_d  = pending_q;
          if (newreq_s) hold_d = req_s;
          else          hold_d = MODE_OFF;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          if (newreq_s) pending_d = req_s;
          else          pending_d = pending_q;
        end
      end
      default: begin
        state_d = S_RUN;
        cnt_d   = CNT_ZERO;
      end
    endcase
    fy_d   = (state_d == S_YELLOW);
    fr_d   = (state_d == S_ALLRED);
    busy_d = (state_d != S_RUN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_RUN;
      cnt_q     <= CNT_ZERO;
      pending_q <= MODE_OFF;
      mode_q    <= MODE_OFF;
      hold_q    <= MODE_OFF;
      fy_q      <= 1'b0;
      fr_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      mode_q    <= mode_d;
      hold_q    <= hold_d;
      fy_q      <= fy_d;
      fr_q      <= fr_d;
      busy_q    <= busy_d;
    end
  end

  assign mode_sel     = mode_q;
  assign force_yellow = fy_q;
  assign force_red    = fr_q;
  assign sub_reset    = fr_q;
  assign busy         = busy_q;

endmodule
